// File: rtl/divider.sv
// Iterative radix-2 restoring divider, signed/unsigned, s = {remainder, quotient}.
// Optional output div_zero is enabled by defining DIVIDER_DIVZERO_FLAG_EN.
module divider #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic               start,
    input  logic               is_signed,
    output logic [2*WIDTH-1:0] s,
    output logic               ready
`ifdef DIVIDER_DIVZERO_FLAG_EN
    ,
    output logic               div_zero
`endif
);

    localparam int            CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, BUSY, FIX} state_t;

    state_t state, state_nxt;

    logic [CW-1:0]           cnt;
    logic [WIDTH-1:0]        rem, quo, dvs;
    logic                    neg_q, neg_r;
    logic signed [WIDTH-1:0] a_s, b_s;
    logic                    a_neg, b_neg, b_zero, launch;
    logic [WIDTH:0]          rem_sh;
    logic [WIDTH-1:0]        rem_sub;
    logic                    take;
`ifdef DIVIDER_DIVZERO_FLAG_EN
    logic                    bzero;
`endif

    function automatic logic [WIDTH-1:0] cond_negate(input logic [WIDTH-1:0] v,
                                                      input logic           neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

    assign a_s    = signed'(a);
    assign b_s    = signed'(b);
    assign a_neg  = is_signed && (a_s < 0);
    assign b_neg  = is_signed && (b_s < 0);
    assign b_zero = (b == '0);
    assign launch = (state == IDLE) && start;

    // One restoring step: the shifted remainder needs WIDTH+1 bits, the
    // difference always fits back into WIDTH bits when it is taken.
    assign rem_sh  = {rem, quo[WIDTH-1]};
    assign take    = (rem_sh >= {1'b0, dvs});
    assign rem_sub = rem_sh[WIDTH-1:0] - dvs;

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        case (state)
            IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = BUSY;
            end
            BUSY:    if (cnt == LAST) state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            s     <= '0;
        end else begin
            state <= state_nxt;
            if (launch)
                cnt <= '0;
            else if (state == BUSY)
                cnt <= cnt + 1'b1;
            if (state == FIX)
                s <= {cond_negate(rem, neg_r), cond_negate(quo, neg_q)};
        end
    end

`ifdef DIVIDER_DIVZERO_FLAG_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            div_zero <= 1'b0;
        else if (state == FIX)
            div_zero <= bzero;
    end

    always_ff @(posedge clk) begin
        if (launch) bzero <= b_zero;
    end
`endif

    // Datapath: magnitudes loaded at launch, shifted/subtracted while busy.
    // With a zero divisor every step takes, leaving quo all ones and rem = |a|;
    // re-applying the dividend sign then reproduces the original a.
    always_ff @(posedge clk) begin
        if (launch) begin
            quo   <= cond_negate(a, a_neg);
            dvs   <= cond_negate(b, b_neg);
            rem   <= '0;
            neg_q <= (a_neg ^ b_neg) && !b_zero;
            neg_r <= a_neg;
        end else if (state == BUSY) begin
            rem <= take ? rem_sub : rem_sh[WIDTH-1:0];
            quo <= {quo[WIDTH-2:0], take};
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: fixed vectors, handshake corner cases, random ops.
module tb_divider;

    logic        clk;
    logic        reset;
    logic [31:0] a, b;
    logic        start, is_signed;
    logic [63:0] s;
    logic        ready;
`ifdef DIVIDER_DIVZERO_FLAG_EN
    logic        div_zero;
`endif

    int          checks   = 0;
    int          failures = 0;
    logic [63:0] sb[$];
    logic [63:0] last_exp = '0;

    divider #(.WIDTH(32)) dut (
        .clk(clk),
        .reset(reset),
        .a(a),
        .b(b),
        .start(start),
        .is_signed(is_signed),
        .s(s),
        .ready(ready)
`ifdef DIVIDER_DIVZERO_FLAG_EN
        ,
        .div_zero(div_zero)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y,
                                          input logic sg);
        logic signed [31:0] sx, sy;
        sx = signed'(x);
        sy = signed'(y);
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        if (!sg) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        return {32'(sx % sy), 32'(sx / sy)};
    endfunction

    // Present an operation and clock the start edge; start stays as driven.
    task automatic issue(input logic [31:0] x, input logic [31:0] y, input logic sg,
                         input logic [63:0] exp);
        a         = x;
        b         = y;
        is_signed = sg;
        start     = 1'b1;
        sb.push_back(exp);
        @(posedge clk);
        #1;
    endtask

    // Wait for completion; pulse_at >= 0 fires a stray start with new operands.
    task automatic finish_op(input string tag, input int pulse_at, input logic hold);
        int          lat;
        logic [63:0] exp;
        check({tag, "_busy"}, 64'(ready), 64'd0);
        lat = 0;
        while (!ready && lat < 60) begin
            if (lat == pulse_at) begin
                a     = 32'd1;
                b     = 32'd1;
                start = 1'b1;
            end else if (!hold) begin
                start = 1'b0;
            end
            if (lat == 16) check({tag, "_hold"}, s, last_exp);
            @(posedge clk);
            #1;
            lat++;
        end
        if (!hold) start = 1'b0;
        check({tag, "_lat"}, 64'(lat), 64'd33);
        if (sb.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            exp = sb.pop_front();
            check(tag, s, exp);
            last_exp = exp;
        end
    endtask

    task automatic run(input string tag, input logic [31:0] x, input logic [31:0] y,
                       input logic sg, input logic [63:0] exp);
        issue(x, y, sg, exp);
        finish_op(tag, -1, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rx, ry;
        logic        rs;
        reset     = 1'b1;
        start     = 1'b0;
        a         = '0;
        b         = '0;
        is_signed = 1'b0;
        #12;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_ready", 64'(ready), 64'd1);
        check("rst_s", s, 64'd0);
`ifdef DIVIDER_DIVZERO_FLAG_EN
        check("rst_dz", 64'(div_zero), 64'd0);
`endif

        run("u_2003_99", 32'd2003, 32'd99, 1'b0, {32'd23, 32'd20});
        run("u_big", 32'd987654321, 32'd123456789, 1'b0, {32'd9, 32'd8});
        run("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, {32'd0, 32'hFFFF_FFFF});
        run("s_m602_5", 32'hFFFF_FDA6, 32'd5, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FF88});
        run("s_min_m1", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, {32'd0, 32'h8000_0000});
        run("s_7_0", 32'd7, 32'd0, 1'b1, {32'h7, 32'hFFFF_FFFF});
`ifdef DIVIDER_DIVZERO_FLAG_EN
        check("dz_set_s", 64'(div_zero), 64'd1);
`endif
        run("u_7_0", 32'd7, 32'd0, 1'b0, {32'h7, 32'hFFFF_FFFF});
`ifdef DIVIDER_DIVZERO_FLAG_EN
        check("dz_set_u", 64'(div_zero), 64'd1);
`endif
        run("u_10_3", 32'd10, 32'd3, 1'b0, {32'd1, 32'd3});
`ifdef DIVIDER_DIVZERO_FLAG_EN
        check("dz_clr", 64'(div_zero), 64'd0);
`endif
        run("s_m5_0", 32'hFFFF_FFFB, 32'd0, 1'b1, {32'hFFFF_FFFB, 32'hFFFF_FFFF});

        // Stray start mid-operation must be ignored.
        issue(32'd2003, 32'd99, 1'b0, {32'd23, 32'd20});
        finish_op("ignore_start", 5, 1'b0);
        @(posedge clk);
        #1;
        check("ignore_idle", 64'(ready), 64'd1);

        // Start held high: back-to-back operations with no idle gap.
        issue(32'd100, 32'd7, 1'b0, {32'd2, 32'd14});
        finish_op("held_1", -1, 1'b1);
        issue(32'hFFFF_FF9C, 32'd7, 1'b1, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        finish_op("held_2", -1, 1'b0);

        // Asynchronous reset in the middle of an operation.
        a     = 32'd1000;
        b     = 32'd3;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midrst_ready", 64'(ready), 64'd1);
        check("midrst_s", s, 64'd0);
        @(posedge clk);
        #1;
        reset    = 1'b0;
        last_exp = '0;
        run("post_rst", 32'd50, 32'd6, 1'b0, {32'd2, 32'd8});

        for (int i = 0; i < 6; i++) begin
            rx = $urandom;
            ry = (i == 5) ? 32'd0 : ($urandom >> $urandom_range(0, 28));
            rs = 1'(i % 2);
            run("rand", rx, ry, rs, model(rx, ry, rs));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
